// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between fetch and load/store.
// Define RISCV_ARB_DMEM_PRIORITY_EN to make load/store win every contention instead.
module riscv_mem_arbiter #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned ADDR_WIDTH   = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  imem_req_in,
  input  logic [ADDR_WIDTH-1:0] imem_addr_in,
  output logic                  imem_gnt_out,
  output logic                  imem_valid_out,
  output logic [31:0]           imem_data_out,
  input  logic                  dmem_req_in,
  input  logic [3:0]            dmem_we_in,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_in,
  input  logic [31:0]           dmem_data_in,
  output logic                  dmem_gnt_out,
  output logic                  dmem_valid_out,
  output logic [31:0]           dmem_data_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [31:0]           mem_data_out,
  output logic [3:0]            mem_write_enable_out,
  input  logic [31:0]           mem_data_in
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;     // 1 = dmem owns the outstanding read
  logic       last_q, last_d;       // 1 = dmem won the most recent grant
  logic       wr_pend_q, wr_pend_d;
  logic       eligible, win_i, win_d, rsp, d_write;

  always_comb begin
    rsp      = (state_q == READ) && (cnt_q == '0);
    // A new grant may overlap the response cycle of the previous read
    eligible = !rst_in && ((state_q == IDLE) || rsp);
`ifdef RISCV_ARB_DMEM_PRIORITY_EN
    win_d    = eligible && dmem_req_in;
`else
    win_d    = eligible && dmem_req_in && (!imem_req_in || !last_q);
`endif
    win_i    = eligible && imem_req_in && !win_d;
    d_write  = win_d && (dmem_we_in != '0);

    imem_gnt_out         = win_i;
    dmem_gnt_out         = win_d;
    mem_addr_out         = '0;
    mem_data_out         = '0;
    mem_write_enable_out = '0;
    if (win_i) mem_addr_out = imem_addr_in;
    if (win_d) mem_addr_out = dmem_addr_in;
    if (d_write) begin
      mem_data_out         = dmem_data_in;
      mem_write_enable_out = dmem_we_in;
    end

    imem_valid_out = rsp && !owner_q;
    imem_data_out  = imem_valid_out ? mem_data_in : '0;
    dmem_valid_out = (rsp && owner_q) || wr_pend_q;
    dmem_data_out  = (rsp && owner_q) ? mem_data_in : '0;

    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    wr_pend_d = d_write;
    if (state_q == READ) begin
      if (cnt_q == '0) state_d = IDLE;
      else             cnt_d   = cnt_q - 3'd1;
    end
    if (win_i || win_d) begin
      last_d = win_d;
      if (!d_write) begin
        state_d = READ;
        cnt_d   = CNT_INIT;
        owner_d = win_d;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      wr_pend_q <= wr_pend_d;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: instance A uses READ_LATENCY=2, instance B uses 3.
module tb_riscv_mem_arbiter;

  typedef struct {
    int          d;
    bit          p;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic        rst_a = 1'b1, ireq_a = 1'b0, dreq_a = 1'b0;
  logic [31:0] iaddr_a = '0, daddr_a = '0, dwd_a = '0;
  logic [3:0]  dwe_a = '0;
  logic        ignt_a, ival_a, dgnt_a, dval_a;
  logic [31:0] idat_a, ddat_a, maddr_a, mwd_a, mrd_a;
  logic [3:0]  mwe_a;

  logic        rst_b = 1'b1, ireq_b = 1'b0, dreq_b = 1'b0;
  logic [31:0] iaddr_b = '0, daddr_b = '0, dwd_b = '0;
  logic [3:0]  dwe_b = '0;
  logic        ignt_b, ival_b, dgnt_b, dval_b;
  logic [31:0] idat_b, ddat_b, maddr_b, mwd_b, mrd_b;
  logic [3:0]  mwe_b;

  riscv_mem_arbiter #(.READ_LATENCY(2), .ADDR_WIDTH(32)) u_dut_a (
    .clk_in(clk), .rst_in(rst_a),
    .imem_req_in(ireq_a), .imem_addr_in(iaddr_a), .imem_gnt_out(ignt_a),
    .imem_valid_out(ival_a), .imem_data_out(idat_a),
    .dmem_req_in(dreq_a), .dmem_we_in(dwe_a), .dmem_addr_in(daddr_a), .dmem_data_in(dwd_a),
    .dmem_gnt_out(dgnt_a), .dmem_valid_out(dval_a), .dmem_data_out(ddat_a),
    .mem_addr_out(maddr_a), .mem_data_out(mwd_a), .mem_write_enable_out(mwe_a),
    .mem_data_in(mrd_a)
  );

  riscv_mem_arbiter #(.READ_LATENCY(3), .ADDR_WIDTH(32)) u_dut_b (
    .clk_in(clk), .rst_in(rst_b),
    .imem_req_in(ireq_b), .imem_addr_in(iaddr_b), .imem_gnt_out(ignt_b),
    .imem_valid_out(ival_b), .imem_data_out(idat_b),
    .dmem_req_in(dreq_b), .dmem_we_in(dwe_b), .dmem_addr_in(daddr_b), .dmem_data_in(dwd_b),
    .dmem_gnt_out(dgnt_b), .dmem_valid_out(dval_b), .dmem_data_out(ddat_b),
    .mem_addr_out(maddr_b), .mem_data_out(mwd_b), .mem_write_enable_out(mwe_b),
    .mem_data_in(mrd_b)
  );

  // Memory model: fixed contents, read data follows the address by the instance latency
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  logic [31:0] pipe_a [0:1];
  logic [31:0] pipe_b [0:2];
  always @(posedge clk) begin
    pipe_a[0] <= maddr_a; pipe_a[1] <= pipe_a[0];
    pipe_b[0] <= maddr_b; pipe_b[1] <= pipe_b[0]; pipe_b[2] <= pipe_b[1];
  end
  assign mrd_a = mem_f(pipe_a[1]);
  assign mrd_b = mem_f(pipe_b[2]);

  localparam bit PI = 1'b0, PD = 1'b1;

  task automatic push(input int d, input bit p, input logic [31:0] data, input int dly);
    exp_t e;
    e.d = d; e.p = p; e.data = data; e.due = cyc + dly;
    sb.push_back(e);
  endtask

  // One cycle: drive inputs after the edge, check grant-path outputs at the falling edge
  task automatic step(input int d, input string nm, input bit rst,
                      input bit ir, input logic [31:0] ia,
                      input bit dr, input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] dd,
                      input bit eig, input bit edg, input logic [31:0] eaddr,
                      input logic [31:0] ewd, input logic [3:0] ewe);
    logic [69:0] got, exp;
    @(posedge clk);
    #1;
    if (d == 0) begin
      rst_a = rst; ireq_a = ir; iaddr_a = ia; dreq_a = dr; dwe_a = dwe; daddr_a = da; dwd_a = dd;
    end else begin
      rst_b = rst; ireq_b = ir; iaddr_b = ia; dreq_b = dr; dwe_b = dwe; daddr_b = da; dwd_b = dd;
    end
    @(negedge clk);
    got = (d == 0) ? {ignt_a, dgnt_a, maddr_a, mwd_a, mwe_a} : {ignt_b, dgnt_b, maddr_b, mwd_b, mwe_b};
    exp = {eig, edg, eaddr, ewd, ewe};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d cyc %0d): gnt_i/gnt_d/addr/wdata/we got %b/%b/%h/%h/%h expected %b/%b/%h/%h/%h",
               nm, d, cyc, got[69], got[68], got[67:36], got[35:4], got[3:0],
               exp[69], exp[68], exp[67:36], exp[35:4], exp[3:0]);
    end
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) step(d, "idle", 1'b0, 0, '0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic mon(input int d, input bit p, input logic v, input logic [31:0] data);
    int idx;
    idx = -1;
    checks++;
    if (v !== 1'b1) begin
      if (v !== 1'b0 || data !== '0) begin
        errors++;
        $display("FAIL idle_data (dut %0d port %0d cyc %0d): valid %b data %h expected valid 0 data 0", d, p, cyc, v, data);
      end
      return;
    end
    foreach (sb[k]) if (idx < 0 && sb[k].d == d && sb[k].p == p) idx = k;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected_valid (dut %0d port %0d cyc %0d): data %h expected no response", d, p, cyc, data);
    end else begin
      if (data !== sb[idx].data || cyc != sb[idx].due) begin
        errors++;
        $display("FAIL response (dut %0d port %0d): data %h at cyc %0d expected %h at cyc %0d",
                 d, p, data, cyc, sb[idx].data, sb[idx].due);
      end
      sb.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    mon(0, PI, ival_a, idat_a);
    mon(0, PD, dval_a, ddat_a);
    mon(1, PI, ival_b, idat_b);
    mon(1, PD, dval_b, ddat_b);
  end

  initial begin
    // Reset state
    step(0, "reset_a", 1'b1, 0, '0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    step(1, "reset_b", 1'b1, 0, '0, 0, '0, '0, '0, 0, 0, '0, '0, '0);

    // Fetch only
    step(0, "fetch_gnt", 1'b0, 1, 32'h100, 0, '0, '0, '0, 1, 0, 32'h100, '0, '0);
    push(0, PI, 32'hDEADBEEF, 2);
    idle(0, 3);

    // Write, then read issued in the very next cycle
    step(0, "write_gnt", 1'b0, 0, '0, 1, 4'b1100, 32'h204, 32'hABCD0000, 0, 1, 32'h204, 32'hABCD0000, 4'b1100);
    push(0, PD, 32'h0, 1);
    step(0, "read_after_write", 1'b0, 0, '0, 1, 4'b0000, 32'h24, 32'h55555555, 0, 1, 32'h24, '0, '0);
    push(0, PD, 32'hFFDB0024, 2);
    idle(0, 3);

    // Contention from reset
    step(0, "reset_pulse", 1'b1, 0, '0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
`ifdef RISCV_ARB_DMEM_PRIORITY_EN
    step(0, "cont0", 1'b0, 1, 32'h10, 1, '0, 32'h20, '0, 0, 1, 32'h20, '0, '0);
    push(0, PD, 32'hFFDF0020, 2);
    step(0, "cont1", 1'b0, 1, 32'h10, 1, '0, 32'h24, '0, 0, 0, '0, '0, '0);
    step(0, "cont2", 1'b0, 1, 32'h10, 1, '0, 32'h24, '0, 0, 1, 32'h24, '0, '0);
    push(0, PD, 32'hFFDB0024, 2);
    step(0, "cont3", 1'b0, 1, 32'h10, 1, '0, 32'h28, '0, 0, 0, '0, '0, '0);
    step(0, "cont4", 1'b0, 1, 32'h10, 1, '0, 32'h28, '0, 0, 1, 32'h28, '0, '0);
    push(0, PD, 32'hFFD70028, 2);
`else
    step(0, "cont0", 1'b0, 1, 32'h10, 1, '0, 32'h20, '0, 1, 0, 32'h10, '0, '0);
    push(0, PI, 32'hFFEF0010, 2);
    step(0, "cont1", 1'b0, 1, 32'h14, 1, '0, 32'h20, '0, 0, 0, '0, '0, '0);
    step(0, "cont2", 1'b0, 1, 32'h14, 1, '0, 32'h20, '0, 0, 1, 32'h20, '0, '0);
    push(0, PD, 32'hFFDF0020, 2);
    step(0, "cont3", 1'b0, 1, 32'h14, 1, '0, 32'h24, '0, 0, 0, '0, '0, '0);
    step(0, "cont4", 1'b0, 1, 32'h14, 1, '0, 32'h24, '0, 1, 0, 32'h14, '0, '0);
    push(0, PI, 32'hFFEB0014, 2);
`endif
    idle(0, 3);

    // dmem read, fetch arrives one cycle later and is granted on the response cycle
    step(0, "dread_gnt", 1'b0, 0, '0, 1, '0, 32'h40, '0, 0, 1, 32'h40, '0, '0);
    push(0, PD, 32'hFFBF0040, 2);
    step(0, "busy_no_gnt", 1'b0, 1, 32'h44, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    step(0, "overlap_gnt", 1'b0, 1, 32'h44, 0, '0, '0, '0, 1, 0, 32'h44, '0, '0);
    push(0, PI, 32'hFFBB0044, 2);
    idle(0, 3);

    // Reset during an outstanding read drops the response
    step(0, "pre_reset_gnt", 1'b0, 1, 32'h8, 0, '0, '0, '0, 1, 0, 32'h8, '0, '0);
    step(0, "mid_reset", 1'b1, 1, 32'h8, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    step(0, "post_reset_gnt", 1'b0, 1, 32'h100, 0, '0, '0, '0, 1, 0, 32'h100, '0, '0);
    push(0, PI, 32'hDEADBEEF, 2);
    idle(0, 3);

    // Latency 3 instance
    step(1, "l3_gnt", 1'b0, 1, 32'h8, 0, '0, '0, '0, 1, 0, 32'h8, '0, '0);
    push(1, PI, 32'hFFF70008, 3);
    step(1, "l3_busy1", 1'b0, 0, '0, 1, '0, 32'h40, '0, 0, 0, '0, '0, '0);
    step(1, "l3_busy2", 1'b0, 0, '0, 1, '0, 32'h40, '0, 0, 0, '0, '0, '0);
    step(1, "l3_dgnt", 1'b0, 0, '0, 1, '0, 32'h40, '0, 0, 1, 32'h40, '0, '0);
    push(1, PD, 32'hFFBF0040, 3);
    idle(1, 4);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    foreach (sb[k]) begin
      checks++;
      errors++;
      $display("FAIL missing_response (dut %0d port %0d): no valid pulse observed, expected %h at cyc %0d",
               sb[k].d, sb[k].p, sb[k].data, sb[k].due);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
